// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic-light display path: phase sequencer,
// lamp decoder and number display all agree on these values.
package traffic_pkg;

  localparam int DEF_CNT_W = 6;

  typedef enum logic [1:0] {
    ST_RED    = 2'b00,
    ST_YELLOW = 2'b01,
    ST_GREEN  = 2'b10,
    ST_FLASH  = 2'b11
  } state_t;

  // Phase that follows s on normal expiry; FLASH is left only via night_mode.
  function automatic state_t next_phase(state_t s);
    case (s)
      ST_RED:   return ST_GREEN;
      ST_GREEN: return ST_YELLOW;
      default:  return ST_RED;
    endcase
  endfunction

endpackage

// File: rtl/light_phase_sequencer_if.sv
// Control/status bundle between the clock divider, pedestrian/night inputs
// and the light phase sequencer. master drives the inputs, slave is the sequencer.
interface light_phase_sequencer_if
  import traffic_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) ();

  logic             tick;
  logic             ped_req;
  logic             night_mode;
  state_t           state;
  logic [CNT_W-1:0] time_left;
  logic             phase_done;
  logic             ped_ack;

  modport master (
    output tick, ped_req, night_mode,
    input  state, time_left, phase_done, ped_ack
  );

  modport slave (
    input  tick, ped_req, night_mode,
    output state, time_left, phase_done, ped_ack
  );

endinterface

// File: rtl/phase_timer.sv
// Loadable down-counter holding the seconds left in the current phase.
// Load has priority over the enabled decrement; the counter saturates at 0.
module phase_timer
  import traffic_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int RST_VAL = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             is_one
);

  logic [CNT_W-1:0] r_count;

  // Counter register: reset to the first phase's duration, else load or count down.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= CNT_W'(RST_VAL);
    end else if (load) begin
      r_count <= load_val;
    end else if (en && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign count  = r_count;
  assign is_one = (r_count == CNT_W'(1));

endmodule

// File: rtl/light_phase_sequencer.sv
// RED -> GREEN -> YELLOW -> RED phase sequencer with per-phase countdown,
// pedestrian green cut and flashing-yellow night mode. Time advances on tick only.
module light_phase_sequencer
  import traffic_pkg::*;
#(
  parameter int CNT_W         = DEF_CNT_W,
  parameter int RED_TIME      = 20,
  parameter int GREEN_TIME    = 30,
  parameter int YELLOW_TIME   = 3,
  parameter int PED_MIN_GREEN = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  light_phase_sequencer_if.slave  bus
);

  localparam int MAX_T = (1 << CNT_W) - 1;

  if ((RED_TIME < 1) || (RED_TIME > MAX_T)) begin : g_bad_red
    $error("RED_TIME out of range 1..2**CNT_W-1");
  end
  if ((GREEN_TIME < 1) || (GREEN_TIME > MAX_T)) begin : g_bad_green
    $error("GREEN_TIME out of range 1..2**CNT_W-1");
  end
  if ((YELLOW_TIME < 1) || (YELLOW_TIME > MAX_T)) begin : g_bad_yellow
    $error("YELLOW_TIME out of range 1..2**CNT_W-1");
  end
  if ((PED_MIN_GREEN < 1) || (PED_MIN_GREEN >= GREEN_TIME)) begin : g_bad_ped
    $error("PED_MIN_GREEN must be 1..GREEN_TIME-1");
  end

  localparam logic [CNT_W-1:0] LP_RED    = CNT_W'(RED_TIME);
  localparam logic [CNT_W-1:0] LP_GREEN  = CNT_W'(GREEN_TIME);
  localparam logic [CNT_W-1:0] LP_YELLOW = CNT_W'(YELLOW_TIME);
  localparam logic [CNT_W-1:0] LP_PED    = CNT_W'(PED_MIN_GREEN);

  function automatic logic [CNT_W-1:0] phase_duration(state_t s);
    case (s)
      ST_GREEN:  return LP_GREEN;
      ST_YELLOW: return LP_YELLOW;
      ST_RED:    return LP_RED;
      default:   return '0;
    endcase
  endfunction

  state_t           r_state;
  logic             r_phase_done;
  logic             r_ped_ack;
  logic             r_ped_pending;

  state_t           w_next_state;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_en;
  logic             w_phase_done;
  logic             w_ped_ack;
  logic             w_ped_clear;
  logic             w_ped_set;
  logic [CNT_W-1:0] w_count;
  logic             w_is_one;

  phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (RED_TIME)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (w_load),
    .load_val (w_load_val),
    .en       (w_en),
    .count    (w_count),
    .is_one   (w_is_one)
  );

  assign w_ped_set = bus.ped_req && ((r_state == ST_GREEN) || (r_state == ST_YELLOW));

  // Tick decision in priority order: night entry, flash hold/exit, expiry, ped cut, count.
  // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_load_val   = '0;
    w_en         = 1'b0;
    w_phase_done = 1'b0;
    w_ped_ack    = 1'b0;
    w_ped_clear  = 1'b0;
    if (bus.tick) begin
      if (bus.night_mode && (r_state != ST_FLASH)) begin
        w_next_state = ST_FLASH;
        w_load       = 1'b1;
        w_phase_done = 1'b1;
        w_ped_clear  = 1'b1;
      end else if (r_state == ST_FLASH) begin
        if (!bus.night_mode) begin
          w_next_state = ST_RED;
          w_load       = 1'b1;
          w_load_val   = LP_RED;
          w_phase_done = 1'b1;
        end
      end else if (w_is_one) begin
        w_next_state = next_phase(r_state);
        w_load       = 1'b1;
        w_load_val   = phase_duration(w_next_state);
        w_phase_done = 1'b1;
        if ((w_next_state == ST_RED) && r_ped_pending) begin
          w_ped_ack   = 1'b1;
          w_ped_clear = 1'b1;
        end
      end else if ((r_state == ST_GREEN) && r_ped_pending && (w_count > LP_PED)) begin
        w_load     = 1'b1;
        w_load_val = LP_PED;
      end else begin
        w_en = 1'b1;
      end
    end
  end

  // FSM and pedestrian-pending registers; a clear beats a same-cycle set.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_RED;
      r_phase_done  <= 1'b0;
      r_ped_ack     <= 1'b0;
      r_ped_pending <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_phase_done <= w_phase_done;
      r_ped_ack    <= w_ped_ack;
      if (w_ped_clear) begin
        r_ped_pending <= 1'b0;
      end else if (w_ped_set) begin
        r_ped_pending <= 1'b1;
      end
    end
  end

  assign bus.state      = r_state;
  assign bus.time_left  = w_count;
  assign bus.phase_done = r_phase_done;
  assign bus.ped_ack    = r_ped_ack;

endmodule
